// File: rtl/regfile_id_ex_if.sv
// ---------------------------------------------------------------------------
// regfile_id_ex_if
// Bundles the decode-side inputs, the write-back port and the latched EX
// register outputs of regfile_id_ex.
//   master : decoder / write-back / EX consumer side (drives id_*, wb_*,
//            stall, flush; observes ex_*)
//   slave  : regfile_id_ex side (observes id_*, wb_*, stall, flush;
//            drives ex_*)
// ---------------------------------------------------------------------------
interface regfile_id_ex_if #(
    parameter int XLEN = 32
);
    // decode side
    logic            id_valid;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     imm;
    logic            stall;
    logic            flush;
    // write-back port
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    // EX register
    logic            ex_valid;
    logic [4:0]      ex_rd;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;

    modport master (
        output id_valid, rd, rs1, rs2, imm, stall, flush,
        output wb_en, wb_rd, wb_data,
        input  ex_valid, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm
    );

    modport slave (
        input  id_valid, rd, rs1, rs2, imm, stall, flush,
        input  wb_en, wb_rd, wb_data,
        output ex_valid, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm
    );
endinterface

// File: rtl/regfile_id_ex.sv
// ---------------------------------------------------------------------------
// regfile_id_ex
// Integer register file with a write-first bypass, followed by the ID/EX
// pipeline register.
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-low; clears the register file and EX register
//   bus   : regfile_id_ex_if.slave
//           id_valid/rd/rs1/rs2/imm : decoded instruction fields
//           stall/flush             : EX register hold / bubble insert
//           wb_en/wb_rd/wb_data     : write-back port (x0 is never written)
//           ex_*                    : latched instruction, operands, immediate
// ---------------------------------------------------------------------------
module regfile_id_ex #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic                clk,
    input logic                reset,
    regfile_id_ex_if.slave     bus
);

    logic [XLEN-1:0] rf [NREG];

    logic [XLEN-1:0] rs1_data_p0;
    logic [XLEN-1:0] rs2_data_p0;
    logic [XLEN-1:0] imm_p0;

    logic            vld_p1;
    logic [4:0]      rd_p1;
    logic [4:0]      rs1_p1;
    logic [4:0]      rs2_p1;
    logic [XLEN-1:0] rs1_data_p1;
    logic [XLEN-1:0] rs2_data_p1;
    logic [XLEN-1:0] imm_p1;

    // A write-back that targets a live (non-zero) register index.
    function automatic logic wb_hit(input logic [4:0] idx);
        return bus.wb_en && (bus.wb_rd == idx) && (idx != 5'd0);
    endfunction

    // Register read with write-first bypass; x0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        else if (wb_hit(idx))
            return bus.wb_data;
        else
            return rf[idx];
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic signed [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

    // ---- stage p0: decode-side operand read ----
    always_comb begin
        rs1_data_p0 = read_reg(bus.rs1);
        rs2_data_p0 = read_reg(bus.rs2);
        imm_p0      = sext_imm(bus.imm);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // ---- stage p1: EX register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            rd_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
        end else if (bus.flush) begin
            vld_p1      <= 1'b0;
            rd_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
        end else if (bus.stall) begin
            // Held operands track write-backs so they never go stale.
            if (wb_hit(rs1_p1))
                rs1_data_p1 <= bus.wb_data;
            if (wb_hit(rs2_p1))
                rs2_data_p1 <= bus.wb_data;
        end else begin
            vld_p1      <= bus.id_valid;
            rd_p1       <= bus.rd;
            rs1_p1      <= bus.rs1;
            rs2_p1      <= bus.rs2;
            rs1_data_p1 <= rs1_data_p0;
            rs2_data_p1 <= rs2_data_p0;
            imm_p1      <= imm_p0;
        end
    end

    assign bus.ex_valid    = vld_p1;
    assign bus.ex_rd       = rd_p1;
    assign bus.ex_rs1      = rs1_p1;
    assign bus.ex_rs2      = rs2_p1;
    assign bus.ex_rs1_data = rs1_data_p1;
    assign bus.ex_rs2_data = rs2_data_p1;
    assign bus.ex_imm      = imm_p1;

endmodule

// File: tb/tb_regfile_id_ex.sv
module tb_regfile_id_ex;

    logic clk;
    logic reset;

    regfile_id_ex_if #(.XLEN(32)) bus ();

    regfile_id_ex #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        idv;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        stall;
        logic        flush;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        ev;
        logic [4:0]  erd;
        logic [4:0]  ers1;
        logic [4:0]  ers2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] eimm;
    } vec_t;

    localparam int NVEC = 17;
    localparam int NSEQ = 5;
    vec_t tbl [NVEC];
    vec_t seq [NSEQ];

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and compare the EX register.
    task automatic apply(input string tag, input int idx, input vec_t v);
        reset       = v.rstn;
        bus.id_valid = v.idv;
        bus.rd      = v.rd;
        bus.rs1     = v.rs1;
        bus.rs2     = v.rs2;
        bus.imm     = v.imm;
        bus.stall   = v.stall;
        bus.flush   = v.flush;
        bus.wb_en   = v.wbe;
        bus.wb_rd   = v.wbrd;
        bus.wb_data = v.wbd;
        @(posedge clk);
        #1;
        cmp({tag, ".ex_valid"},    idx, 32'(bus.ex_valid),  32'(v.ev));
        cmp({tag, ".ex_rd"},       idx, 32'(bus.ex_rd),     32'(v.erd));
        cmp({tag, ".ex_rs1"},      idx, 32'(bus.ex_rs1),    32'(v.ers1));
        cmp({tag, ".ex_rs2"},      idx, 32'(bus.ex_rs2),    32'(v.ers2));
        cmp({tag, ".ex_rs1_data"}, idx, bus.ex_rs1_data,    v.d1);
        cmp({tag, ".ex_rs2_data"}, idx, bus.ex_rs2_data,    v.d2);
        cmp({tag, ".ex_imm"},      idx, bus.ex_imm,         v.eimm);
    endtask

    initial begin
        //           rstn  idv   rd     rs1    rs2    imm       stall flush wbe   wbrd   wbd            ev    erd    ers1   ers2   d1             d2             eimm
        // reset, and write-back ignored while in reset (x6)
        tbl[0]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  12'h000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 5'd1,  5'd2,  5'd3,  12'h7FF, 1'b0, 1'b0, 1'b1, 5'd6,  32'h55,       1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        // negative immediate sign extension
        tbl[2]  = '{1'b1, 1'b1, 5'd1,  5'd3,  5'd0,  12'h800, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  5'd3,  5'd0,  32'h0,        32'h0,        32'hFFFFF800};
        // write-first bypass on rs1; x6 stays 0
        tbl[3]  = '{1'b1, 1'b1, 5'd2,  5'd5,  5'd6,  12'h7FF, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd2,  5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'h000007FF};
        tbl[4]  = '{1'b1, 1'b1, 5'd2,  5'd0,  5'd5,  12'h000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
        // write to x0 ignored, no bypass
        tbl[5]  = '{1'b1, 1'b1, 5'd2,  5'd5,  5'd0,  12'h000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h1234,     1'b1, 5'd2,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 1'b1, 5'd2,  5'd0,  5'd0,  12'h000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        // latch ex_rs2=7 holding 0x10, then stall three cycles
        tbl[7]  = '{1'b1, 1'b1, 5'd3,  5'd1,  5'd7,  12'h123, 1'b0, 1'b0, 1'b1, 5'd7,  32'h10,       1'b1, 5'd3,  5'd1,  5'd7,  32'h0,        32'h10,       32'h00000123};
        tbl[8]  = '{1'b1, 1'b0, 5'd4,  5'd2,  5'd2,  12'hFFF, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd1,  5'd7,  32'h0,        32'h10,       32'h00000123};
        tbl[9]  = '{1'b1, 1'b0, 5'd4,  5'd2,  5'd2,  12'hFFF, 1'b1, 1'b0, 1'b1, 5'd7,  32'h99,       1'b1, 5'd3,  5'd1,  5'd7,  32'h0,        32'h99,       32'h00000123};
        tbl[10] = '{1'b1, 1'b0, 5'd4,  5'd2,  5'd2,  12'hFFF, 1'b1, 1'b0, 1'b1, 5'd1,  32'h42,       1'b1, 5'd3,  5'd1,  5'd7,  32'h42,       32'h99,       32'h00000123};
        // flush beats stall; write-back to x9 still lands
        tbl[11] = '{1'b1, 1'b1, 5'd5,  5'd5,  5'd5,  12'h555, 1'b1, 1'b1, 1'b1, 5'd9,  32'hAA,       1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        // id_valid=0 still latches fields
        tbl[12] = '{1'b1, 1'b0, 5'd4,  5'd9,  5'd7,  12'hFFF, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  5'd9,  5'd7,  32'hAA,       32'h99,       32'hFFFFFFFF};
        // reset during stall clears everything, including x9 and x1
        tbl[13] = '{1'b0, 1'b1, 5'd6,  5'd9,  5'd9,  12'h001, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        tbl[14] = '{1'b1, 1'b1, 5'd0,  5'd9,  5'd1,  12'h000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  5'd1,  32'h0,        32'h0,        32'h0};
        // rs1==rs2 both bypassed
        tbl[15] = '{1'b1, 1'b1, 5'd8,  5'd8,  5'd8,  12'h00A, 1'b0, 1'b0, 1'b1, 5'd8,  32'h77,       1'b1, 5'd8,  5'd8,  5'd8,  32'h77,       32'h77,       32'h0000000A};
        // flush alone
        tbl[16] = '{1'b1, 1'b1, 5'd5,  5'd1,  5'd1,  12'h111, 1'b0, 1'b1, 1'b1, 5'd2,  32'h123,      1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};

        // x31 boundary, stall with a write to x0 while ex_rs1==0, reset during
        // stall+flush, first post-reset edge stalls, then reads cleared x31/x2.
        seq[0]  = '{1'b1, 1'b1, 5'd31, 5'd0,  5'd31, 12'h000, 1'b0, 1'b0, 1'b1, 5'd31, 32'hF0F0,     1'b1, 5'd31, 5'd0,  5'd31, 32'h0,        32'hF0F0,     32'h0};
        seq[1]  = '{1'b1, 1'b0, 5'd1,  5'd1,  5'd1,  12'h001, 1'b1, 1'b0, 1'b1, 5'd0,  32'h5,        1'b1, 5'd31, 5'd0,  5'd31, 32'h0,        32'hF0F0,     32'h0};
        seq[2]  = '{1'b0, 1'b1, 5'd1,  5'd1,  5'd1,  12'h001, 1'b1, 1'b1, 1'b1, 5'd3,  32'h3,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        seq[3]  = '{1'b1, 1'b1, 5'd1,  5'd31, 5'd2,  12'h001, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        seq[4]  = '{1'b1, 1'b1, 5'd1,  5'd31, 5'd2,  12'h001, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  5'd31, 5'd2,  32'h0,        32'h0,        32'h00000001};

        for (int i = 0; i < NVEC; i++)
            apply("tbl", i, tbl[i]);

        for (int i = 0; i < NSEQ; i++)
            apply("seq", i, seq[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
